rob_flush_seq: RTL

- Sequences recovery after a ROB nuke in four phases: quiesce the core, walk the ROB from youngest to oldest, emit RAT restore packets, then release fetch.
- Sits beside the ROB in the retire stage and drives the ROB's walk read port, the RAT restore port and the fetch control.
- Quiesce is a dynamic all-units ack handshake with a timeout, not a fixed wait.

---
 rtl/rob_flush_seq_if.sv | 42 ++++
 rtl/rob_flush_seq.sv | 102 ++++++++++
 2 files changed

// File: rtl/rob_flush_seq_if.sv
// Flush-sequencer bus: ROB nuke request, unit quiesce handshake, ROB walk
// read port, RAT restore port and fetch control.
interface rob_flush_seq_if #(
  parameter int RB_IDX_W  = 4,
  parameter int PRF_W     = 6,
  parameter int NUM_UNITS = 4
);
  logic                 nuke_valid_rb1;
  logic                 nuke_type_rb1;
  logic [RB_IDX_W:0]    head_id;
  logic [RB_IDX_W:0]    tail_id;
  logic                 quiesce_req;
  logic [NUM_UNITS-1:0] quiesce_ack;
  logic                 walk_rd_valid;
  logic [RB_IDX_W:0]    walk_rd_robid;
  logic                 walk_rd_dst_is_reg;
  logic [4:0]           walk_rd_gpr;
  logic [PRF_W-1:0]     walk_rd_pdst_old;
  logic                 restore_valid;
  logic [4:0]           restore_gpr;
  logic [PRF_W-1:0]     restore_prfid;
  logic                 rename_stall;
  logic                 resume_fetch;
  logic                 resume_type;
  logic                 flush_err;

  modport master (
    input  nuke_valid_rb1, nuke_type_rb1, head_id, tail_id, quiesce_ack,
           walk_rd_dst_is_reg, walk_rd_gpr, walk_rd_pdst_old,
    output quiesce_req, walk_rd_valid, walk_rd_robid, restore_valid,
           restore_gpr, restore_prfid, rename_stall, resume_fetch,
           resume_type, flush_err
  );

  modport slave (
    output nuke_valid_rb1, nuke_type_rb1, head_id, tail_id, quiesce_ack,
           walk_rd_dst_is_reg, walk_rd_gpr, walk_rd_pdst_old,
    input  quiesce_req, walk_rd_valid, walk_rd_robid, restore_valid,
           restore_gpr, restore_prfid, rename_stall, resume_fetch,
           resume_type, flush_err
  );
endinterface

// File: rtl/rob_flush_seq.sv
// ROB nuke recovery sequencer: quiesce units, walk ROB youngest to oldest,
// emit RAT restores, then release fetch.
module rob_flush_seq #(
  parameter int RB_IDX_W        = 4,
  parameter int PRF_W           = 6,
  parameter int NUM_UNITS       = 4,
  parameter int QUIESCE_TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            reset,
  rob_flush_seq_if.master bus
);
  localparam int ID_W  = RB_IDX_W + 1;
  localparam int TMR_W = $clog2(QUIESCE_TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, QUIESCE, WALK, RESUME} state_t;

  state_t           state;
  logic [ID_W-1:0]  wp;
  logic [TMR_W-1:0] tmr;
  logic             nuke_type_q;
  logic             rd_v_q;
  logic [ID_W-1:0]  wp_dec;
  logic [ID_W-1:0]  wp_dec2;

  assign wp_dec  = wp - ID_W'(1);
  assign wp_dec2 = wp - ID_W'(2);

  // Sequencer FSM with registered outputs.
  // Outputs are computed for the state being entered, so the walk read for
  // the next cycle is decided one cycle early from wp and head_id; head_id is
  // stable while rename_stall is high, so this matches a live compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      wp                <= '0;
      tmr               <= '0;
      nuke_type_q       <= 1'b0;
      bus.quiesce_req   <= 1'b0;
      bus.walk_rd_valid <= 1'b0;
      bus.walk_rd_robid <= '0;
      bus.rename_stall  <= 1'b0;
      bus.resume_fetch  <= 1'b0;
      bus.resume_type   <= 1'b0;
      bus.flush_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.nuke_valid_rb1) begin
            state            <= QUIESCE;
            wp               <= bus.tail_id;
            nuke_type_q      <= bus.nuke_type_rb1;
            tmr              <= TMR_W'(QUIESCE_TIMEOUT);
            bus.quiesce_req  <= 1'b1;
            bus.rename_stall <= 1'b1;
          end
        end
        QUIESCE: begin
          if ((&bus.quiesce_ack) || (tmr == '0)) begin
            if (!(&bus.quiesce_ack))
              bus.flush_err <= 1'b1;
            state             <= WALK;
            bus.quiesce_req   <= 1'b0;
            bus.walk_rd_valid <= (wp != bus.head_id);
            bus.walk_rd_robid <= wp_dec;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        WALK: begin
          if (wp == bus.head_id) begin
            state             <= RESUME;
            bus.walk_rd_valid <= 1'b0;
            bus.resume_fetch  <= 1'b1;
            bus.resume_type   <= nuke_type_q;
          end else begin
            wp                <= wp_dec;
            bus.walk_rd_valid <= (wp_dec != bus.head_id);
            bus.walk_rd_robid <= wp_dec2;
          end
        end
        RESUME: begin
          state            <= IDLE;
          bus.resume_fetch <= 1'b0;
          bus.resume_type  <= 1'b0;
          bus.rename_stall <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Restore stage: marks the cycle in which walk read data is returned.
  always_ff @(posedge clk) begin
    if (reset) rd_v_q <= 1'b0;
    else       rd_v_q <= bus.walk_rd_valid;
  end

  assign bus.restore_valid = rd_v_q & bus.walk_rd_dst_is_reg;
  assign bus.restore_gpr   = rd_v_q ? bus.walk_rd_gpr : '0;
  assign bus.restore_prfid = rd_v_q ? bus.walk_rd_pdst_old : '0;
endmodule
